// File: rtl/doppler_ramp_ctrl_pkg.sv
// Shared types and constants for the doppler NCO ramp controller.
// Config opcodes, FSM states and the saturation limits of the frequency words.
package doppler_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_LOAD_FREQ  = 3'd0,
      OP_LOAD_RATE  = 3'd1,
      OP_LOAD_COUNT = 3'd2,
      OP_START      = 3'd3,
      OP_STOP       = 3'd4,
      OP_CLR_OVR    = 3'd5,
      OP_RSVD6      = 3'd6,
      OP_RSVD7      = 3'd7
   } cfg_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } ctrl_state_t;

   localparam logic signed [31:0] FREQ_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] FREQ_MIN = 32'sh8000_0000;

endpackage

// File: rtl/doppler_ramp_ctrl_if.sv
// Host-side configuration command port of the doppler ramp controller.
interface doppler_ramp_ctrl_if #(
   parameter int CH_W = 2
) ();

   logic            cfg_valid;
   logic            cfg_ready;
   logic [CH_W-1:0] cfg_ch;
   logic [2:0]      cfg_op;
   logic [31:0]     cfg_data;

   modport master (
      output cfg_valid, cfg_ch, cfg_op, cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_op, cfg_data,
      output cfg_ready
   );

endinterface

// File: rtl/doppler_ramp_ctrl_sat_add.sv
// 32-bit signed adder clamping to FREQ_MAX/FREQ_MIN instead of wrapping.
module doppler_sat_add
   import doppler_ctrl_pkg::*;
(
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [31:0] sum
);

   logic [32:0] wide;

   // Overflow shows up as disagreement between the two top bits of the sign-extended sum.
   always_comb begin
      wide = {a[31], a} + {b[31], b};
      if (wide[32] != wide[31]) begin
         sum = wide[32] ? FREQ_MIN : FREQ_MAX;
      end else begin
         sum = wide[31:0];
      end
   end

endmodule

// File: rtl/doppler_ramp_ctrl.sv
// Epoch-driven doppler ramp sequencer: on each tick, scans all NCO channels through
// one shared saturating adder; between scans accepts one config command per cycle.
module doppler_ramp_ctrl
   import doppler_ctrl_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 epoch_tick,
   doppler_ramp_ctrl_if.slave   cfg,
   output logic [NUM_CH-1:0]    nco_enable,
   output logic [NUM_CH*32-1:0] nco_freq,
   output logic                 busy,
   output logic                 epoch_overrun
);

   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

   ctrl_state_t        state;
   logic [CH_W-1:0]    idx;
   logic signed [31:0] freq_q  [NUM_CH];
   logic signed [31:0] rate_q  [NUM_CH];
   logic [31:0]        count_q [NUM_CH];
   logic [NUM_CH-1:0]  en_q;

   logic               cfg_accept;
   logic               ch_hit;
   logic               upd_hit;
   cfg_op_t            op;
   logic signed [31:0] add_a;
   logic signed [31:0] add_b;
   logic signed [31:0] sat_sum;

   assign cfg.cfg_ready = (state == IDLE) && !epoch_tick;
   assign cfg_accept    = cfg.cfg_valid && cfg.cfg_ready;
   assign ch_hit        = int'(cfg.cfg_ch) < NUM_CH;
   assign op            = cfg_op_t'(cfg.cfg_op);

   assign add_a   = freq_q[idx];
   assign add_b   = rate_q[idx];
   assign upd_hit = (state == SCAN) && en_q[idx] && (count_q[idx] != '0);

   doppler_sat_add u_sat_add (
      .a   (add_a),
      .b   (add_b),
      .sum (sat_sum)
   );

   // A tick seen while scanning is dropped, only flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         busy          <= 1'b0;
         epoch_overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (epoch_tick) begin
                  state <= SCAN;
                  busy  <= 1'b1;
                  idx   <= '0;
               end else if (cfg_accept && ch_hit && op == OP_CLR_OVR) begin
                  epoch_overrun <= 1'b0;
               end
            end
            SCAN: begin
               if (epoch_tick) begin
                  epoch_overrun <= 1'b1;
               end
               if (idx == LAST_IDX) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               idx   <= '0;
            end
         endcase
      end
   end

   // Scan updates and config writes never coincide: commands are only accepted in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            freq_q[k]  <= '0;
            rate_q[k]  <= '0;
            count_q[k] <= '0;
         end
         en_q <= '0;
      end else if (upd_hit) begin
         freq_q[idx]  <= sat_sum;
         count_q[idx] <= count_q[idx] - 1'b1;
      end else if (cfg_accept && ch_hit) begin
         case (op)
            OP_LOAD_FREQ:  freq_q[cfg.cfg_ch]  <= cfg.cfg_data;
            OP_LOAD_RATE:  rate_q[cfg.cfg_ch]  <= cfg.cfg_data;
            OP_LOAD_COUNT: count_q[cfg.cfg_ch] <= cfg.cfg_data;
            OP_START:      en_q[cfg.cfg_ch]    <= 1'b1;
            OP_STOP:       en_q[cfg.cfg_ch]    <= 1'b0;
            default:       ;
         endcase
      end
   end

   always_comb begin
      nco_freq = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         nco_freq[32*k +: 32] = freq_q[k];
      end
   end

   assign nco_enable = en_q;

endmodule

// File: tb/tb_doppler_ramp_ctrl.sv
// Scoreboard bench for doppler_ramp_ctrl: a reference model predicts each scan's
// result when the tick is driven; the monitor compares when busy falls.
module tb_doppler_ramp_ctrl;
   import doppler_ctrl_pkg::*;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 epoch_tick = 1'b0;
   logic [NUM_CH-1:0]    nco_enable;
   logic [NUM_CH*32-1:0] nco_freq;
   logic                 busy;
   logic                 epoch_overrun;

   doppler_ramp_ctrl_if #(.CH_W(CH_W)) cfg_if ();

   doppler_ramp_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .epoch_tick    (epoch_tick),
      .cfg           (cfg_if.slave),
      .nco_enable    (nco_enable),
      .nco_freq      (nco_freq),
      .busy          (busy),
      .epoch_overrun (epoch_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model
   logic [31:0]       m_freq  [NUM_CH];
   logic [31:0]       m_rate  [NUM_CH];
   logic [31:0]       m_count [NUM_CH];
   logic [NUM_CH-1:0] m_en;

   typedef struct {
      logic [NUM_CH*32-1:0] freq;
      logic [NUM_CH-1:0]    en;
   } scan_exp_t;

   scan_exp_t sb_q[$];

   function automatic logic [31:0] sat_ref(input logic [31:0] a, input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > SMAX) return 32'h7FFF_FFFF;
      if (s < SMIN) return 32'h8000_0000;
      return s[31:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         m_freq[k]  = '0;
         m_rate[k]  = '0;
         m_count[k] = '0;
      end
      m_en = '0;
   endtask

   task automatic model_tick();
      scan_exp_t e;
      for (int k = 0; k < NUM_CH; k++) begin
         if (m_en[k] && m_count[k] != 0) begin
            m_freq[k]  = sat_ref(m_freq[k], m_rate[k]);
            m_count[k] = m_count[k] - 1;
         end
         e.freq[32*k +: 32] = m_freq[k];
      end
      e.en = m_en;
      sb_q.push_back(e);
   endtask

   task automatic model_cmd(input logic [2:0] op, input int ch, input logic [31:0] data);
      case (op)
         3'd0: m_freq[ch]  = data;
         3'd1: m_rate[ch]  = data;
         3'd2: m_count[ch] = data;
         3'd3: m_en[ch]    = 1'b1;
         3'd4: m_en[ch]    = 1'b0;
         default: ;
      endcase
   endtask

   // Monitor: a scan is complete when busy falls.
   int        busy_len = 0;
   int        scan_cnt = 0;
   logic      prev_busy = 1'b0;
   scan_exp_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy) begin
            busy_len++;
         end else if (prev_busy) begin
            scan_cnt++;
            check_eq("busy_len", busy_len, NUM_CH);
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", sb_q.size(), 1);
            end else begin
               mon_e = sb_q.pop_front();
               for (int k = 0; k < NUM_CH; k++)
                  check_eq($sformatf("scan_freq%0d", k), nco_freq[32*k +: 32], mon_e.freq[32*k +: 32]);
               check_eq("scan_en", nco_enable, mon_e.en);
            end
            busy_len = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic pulse_tick();
      @(posedge clk) #1 epoch_tick = 1'b1;
      @(posedge clk) #1 epoch_tick = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4 * NUM_CH; i++) begin
         @(negedge clk);
         if (!busy) begin
            @(negedge clk);
            return;
         end
      end
      check_eq("idle_timeout", busy, 1'b0);
   endtask

   task automatic epoch();
      model_tick();
      pulse_tick();
      wait_idle();
   endtask

   task automatic send_cmd(input logic [2:0] op, input int ch, input logic [31:0] data,
                           output int waits);
      logic accepted;
      @(posedge clk) #1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_op    = op;
      cfg_if.cfg_ch    = ch[CH_W-1:0];
      cfg_if.cfg_data  = data;
      waits    = 0;
      accepted = 1'b0;
      for (int i = 0; i < 8 * NUM_CH; i++) begin
         @(negedge clk);
         if (cfg_if.cfg_ready) begin
            accepted = 1'b1;
            break;
         end
         waits++;
      end
      if (accepted) begin
         @(posedge clk) #1;
         model_cmd(op, ch, data);
      end else begin
         check_eq("cmd_timeout", cfg_if.cfg_ready, 1'b1);
      end
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic cmd(input logic [2:0] op, input int ch, input logic [31:0] data);
      int w;
      send_cmd(op, ch, data, w);
   endtask

   task automatic compare_all(input string tag);
      for (int k = 0; k < NUM_CH; k++)
         check_eq($sformatf("%s_freq%0d", tag, k), nco_freq[32*k +: 32], m_freq[k]);
      check_eq({tag, "_en"}, nco_enable, m_en);
   endtask

   task automatic overrun_case(input int gap);
      int start_cnt;
      int w;
      start_cnt = scan_cnt;
      model_tick();
      @(posedge clk) #1 epoch_tick = 1'b1;
      @(posedge clk) #1 epoch_tick = 1'b0;
      repeat (gap - 1) @(posedge clk);
      #1 epoch_tick = 1'b1;
      @(posedge clk) #1 epoch_tick = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check_eq($sformatf("ovr_flag_gap%0d", gap), epoch_overrun, 1'b1);
      check_eq($sformatf("ovr_scans_gap%0d", gap), scan_cnt - start_cnt, 1);
      send_cmd(3'd5, 0, 32'h0, w);
      check_eq($sformatf("ovr_clr_gap%0d", gap), epoch_overrun, 1'b0);
   endtask

   int exp1[5] = '{700, 400, 100, 100, 100};
   int w;

   initial begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_op    = '0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_data  = '0;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_freq", nco_freq[31:0] | nco_freq[63:32] | nco_freq[95:64] | nco_freq[127:96], 32'h0);
      check_eq("rst_en", nco_enable, 4'b0000);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_ovr", epoch_overrun, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", cfg_if.cfg_ready, 1'b1);

      // Basic ramp on ch1 with per-channel visibility timing on the first epoch
      cmd(3'd0, 1, 32'd1000);
      cmd(3'd1, 1, -32'sd300);
      cmd(3'd2, 1, 32'd3);
      cmd(3'd3, 1, 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            model_tick();
            pulse_tick();
            @(negedge clk) check_eq("ch1_t1", nco_freq[63:32], 32'd1000);
            @(negedge clk) check_eq("ch1_t2", nco_freq[63:32], 32'd1000);
            @(negedge clk) check_eq("ch1_t3", nco_freq[63:32], 32'd700);
            wait_idle();
         end else begin
            epoch();
         end
         check_eq($sformatf("ch1_ramp%0d", i), nco_freq[63:32], exp1[i]);
         check_eq("en_0010", nco_enable, 4'b0010);
      end

      // Positive and negative saturation
      cmd(3'd0, 0, 32'h7FFF_FF00);
      cmd(3'd1, 0, 32'h0000_0200);
      cmd(3'd2, 0, 32'd2);
      cmd(3'd3, 0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         epoch();
         check_eq($sformatf("sat_pos%0d", i), nco_freq[31:0], 32'h7FFF_FFFF);
      end
      cmd(3'd0, 3, 32'h8000_0100);
      cmd(3'd1, 3, -32'sh200);
      cmd(3'd2, 3, 32'd2);
      cmd(3'd3, 3, 32'h0);
      for (int i = 0; i < 2; i++) begin
         epoch();
         check_eq($sformatf("sat_neg%0d", i), nco_freq[127:96], 32'h8000_0000);
      end

      // Tick and START on the same cycle: tick wins, START lands at T+NUM_CH+1
      cmd(3'd0, 2, 32'd50);
      cmd(3'd1, 2, 32'd5);
      cmd(3'd2, 2, 32'd10);
      model_tick();
      fork
         pulse_tick();
         send_cmd(3'd3, 2, 32'h0, w);
      join
      check_eq("coll_wait", w, NUM_CH + 1);
      check_eq("coll_ch2_hold", nco_freq[95:64], 32'd50);
      check_eq("coll_en2", nco_enable[2], 1'b1);
      epoch();
      check_eq("coll_ch2_step", nco_freq[95:64], 32'd55);

      // Overrun mid-scan and on the final scan cycle
      overrun_case(1);
      overrun_case(NUM_CH);

      // STOP mid-ramp preserves state; START resumes
      cmd(3'd0, 1, 32'd1000);
      cmd(3'd2, 1, 32'd3);
      epoch();
      epoch();
      check_eq("stop_pre", nco_freq[63:32], 32'd400);
      cmd(3'd4, 1, 32'h0);
      check_eq("stop_en1", nco_enable[1], 1'b0);
      epoch();
      check_eq("stop_hold", nco_freq[63:32], 32'd400);
      cmd(3'd3, 1, 32'h0);
      epoch();
      check_eq("stop_resume", nco_freq[63:32], 32'd100);

      // Reserved opcode is accepted with no effect
      send_cmd(3'd6, 0, 32'hDEAD_BEEF, w);
      check_eq("rsvd_accept", w, 0);
      compare_all("rsvd");

      // Asynchronous reset in the middle of a scan
      model_tick();
      pulse_tick();
      @(posedge clk) #2 rst_n = 1'b0;
      #1;
      check_eq("arst_freq", nco_freq[31:0] | nco_freq[63:32] | nco_freq[95:64] | nco_freq[127:96], 32'h0);
      check_eq("arst_en", nco_enable, 4'b0000);
      check_eq("arst_busy", busy, 1'b0);
      sb_q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("arst_ready", cfg_if.cfg_ready, 1'b1);
      @(negedge clk);
      check_eq("arst_idle", busy, 1'b0);

      cmd(3'd0, 0, 32'd10);
      cmd(3'd1, 0, 32'd1);
      cmd(3'd2, 0, 32'd1);
      cmd(3'd3, 0, 32'h0);
      epoch();
      check_eq("post_rst_ch0", nco_freq[31:0], 32'd11);
      compare_all("final");
      check_eq("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
